// File: rtl/hgdb_bp_arbiter.sv
// -----------------------------------------------------------------------------
// hgdb_bp_arbiter
//
// Collects breakpoint-hit requests from NUM_REQ requesters, selects one
// round-robin, offers it to the debugger runtime as an event, stalls the
// design while the runtime services it, and acks the requester on resume.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NUM_REQ]           per-requester hit request (held until ack)
//   req_id     in   [NUM_REQ*ID_WIDTH]  per-requester breakpoint ID, slice i at i*ID_WIDTH
//   bp_enable  in   [NUM_REQ]           per-requester enable mask
//   evt_valid  out  event offered to the runtime
//   evt_ready  in   runtime accepts the event
//   evt_src    out  [clog2(NUM_REQ)]    granted requester index
//   evt_id     out  [ID_WIDTH]          granted breakpoint ID
//   resume     in   single-cycle release pulse from the runtime
//   halt       out  design stall while a breakpoint is in service
//   req_ack    out  [NUM_REQ]           one-hot single-cycle completion pulse
//   hit_count  out  [16]                serviced breakpoints, saturating at 0xFFFF
// -----------------------------------------------------------------------------
module hgdb_bp_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 16,
  localparam int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*ID_WIDTH-1:0]  req_id,
  input  logic [NUM_REQ-1:0]           bp_enable,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic [SRC_W-1:0]             evt_src,
  output logic [ID_WIDTH-1:0]          evt_id,
  input  logic                         resume,
  output logic                         halt,
  output logic [NUM_REQ-1:0]           req_ack,
  output logic [15:0]                  hit_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t                state_reg;
  state_t                state_next;
  logic [SRC_W-1:0]      ptr_reg;
  logic [SRC_W-1:0]      evt_src_reg;
  logic [ID_WIDTH-1:0]   evt_id_reg;
  logic [NUM_REQ-1:0]    ack_reg;
  logic [15:0]           hit_reg;

  logic [NUM_REQ-1:0]    eligible;
  logic                  grant_found;
  logic [SRC_W-1:0]      grant_idx;
  logic                  load_grant;
  logic                  do_ack;

  // Unpack the flat ID bus into one entry per requester.
  logic [ID_WIDTH-1:0]   id_slice [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_id_slice
    assign id_slice[gi] = req_id[gi*ID_WIDTH +: ID_WIDTH];
  end

  // A requester that is being acked this cycle is still holding req_valid,
  // so it is masked out to avoid granting the same hit twice.
  assign eligible = req_valid & bp_enable & ~ack_reg;

  // Round-robin search starting just after the last serviced requester.
  always_comb begin
    logic [SRC_W-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = SRC_W'((int'(ptr_reg) + k) % NUM_REQ);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_next = state_reg;
    load_grant = 1'b0;
    do_ack     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (grant_found) begin
          state_next = ST_ISSUE;
          load_grant = 1'b1;
        end
      end
      ST_ISSUE: begin
        // Event stays offered with latched src/id until the runtime takes it.
        if (evt_ready) begin
          state_next = ST_HALT;
        end
      end
      ST_HALT: begin
        if (resume) begin
          state_next = ST_IDLE;
          do_ack     = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers. A reset mid-service simply drops the
  // pending event: no ack is produced because ack_reg is cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      ptr_reg     <= SRC_W'(NUM_REQ - 1);
      evt_src_reg <= '0;
      evt_id_reg  <= '0;
      ack_reg     <= '0;
      hit_reg     <= 16'd0;
    end else begin
      state_reg <= state_next;

      if (load_grant) begin
        evt_src_reg <= grant_idx;
        evt_id_reg  <= id_slice[grant_idx];
      end

      if (do_ack) begin
        ack_reg <= NUM_REQ'(1) << evt_src_reg;
        ptr_reg <= evt_src_reg;
        if (hit_reg != 16'hFFFF) begin
          hit_reg <= hit_reg + 16'd1;
        end
      end else begin
        ack_reg <= '0;
      end
    end
  end

  assign evt_valid = (state_reg == ST_ISSUE);
  assign halt      = (state_reg != ST_IDLE);
  assign evt_src   = evt_src_reg;
  assign evt_id    = evt_id_reg;
  assign req_ack   = ack_reg;
  assign hit_count = hit_reg;

endmodule

// File: tb/tb_hgdb_bp_arbiter.sv
// -----------------------------------------------------------------------------
// tb_hgdb_bp_arbiter
//
// Self-checking bench for hgdb_bp_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference
// model that tracks the pending breakpoint, the last-served requester and
// the saturating service count.
// -----------------------------------------------------------------------------
module tb_hgdb_bp_arbiter;

  localparam int N  = 4;
  localparam int IW = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N*IW-1:0]   req_id;
  logic [N-1:0]      bp_enable;
  logic              evt_valid;
  logic              evt_ready;
  logic [1:0]        evt_src;
  logic [IW-1:0]     evt_id;
  logic              resume;
  logic              halt;
  logic [N-1:0]      req_ack;
  logic [15:0]       hit_count;

  always #5 clk = ~clk;

  hgdb_bp_arbiter #(.NUM_REQ(N), .ID_WIDTH(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_id    (req_id),
    .bp_enable (bp_enable),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_src   (evt_src),
    .evt_id    (evt_id),
    .resume    (resume),
    .halt      (halt),
    .req_ack   (req_ack),
    .hit_count (hit_count)
  );

  int n_vec = 0;
  int n_err = 0;
  bit quiet = 1'b0;

  // ---------------------------------------------------------------------------
  // Reference model: phase 0 = nothing pending, 1 = event offered,
  // 2 = runtime owns the halt. Grant order is "first eligible after the last
  // served requester, wrapping modulo N".
  // ---------------------------------------------------------------------------
  int            m_phase;
  int            m_src;
  logic [IW-1:0] m_id;
  int            m_last;
  int            m_cnt;
  logic [N-1:0]  m_ack;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_src   = 0;
      m_id    = '0;
      m_last  = N - 1;
      m_cnt   = 0;
      m_ack   = '0;
    end else begin
      logic [N-1:0] nxt_ack;
      logic [N-1:0] elig;
      int           c;
      nxt_ack = '0;
      elig    = req_valid & bp_enable & ~m_ack;
      if (m_phase == 0) begin
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (m_phase == 0 && elig[c[1:0]]) begin
            m_phase = 1;
            m_src   = c;
            m_id    = req_id[c*IW +: IW];
          end
        end
      end else if (m_phase == 1) begin
        if (evt_ready) m_phase = 2;
      end else begin
        if (resume) begin
          m_phase = 0;
          nxt_ack = N'(1) << m_src;
          m_last  = m_src;
          if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end
      end
      m_ack = nxt_ack;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("evt_valid", 32'(evt_valid), 32'(m_phase == 1));
    chk("halt",      32'(halt),      32'(m_phase != 0));
    chk("evt_src",   32'(evt_src),   32'(m_src));
    chk("evt_id",    32'(evt_id),    32'(m_id));
    chk("req_ack",   32'(req_ack),   32'(m_ack));
    chk("hit_count", 32'(hit_count), 32'(m_cnt));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_evt_valid"}, 32'(evt_valid), 32'd0);
    chk({tag, "_halt"},      32'(halt),      32'd0);
    chk({tag, "_req_ack"},   32'(req_ack),   32'd0);
    chk({tag, "_evt_src"},   32'(evt_src),   32'd0);
    chk({tag, "_evt_id"},    32'(evt_id),    32'd0);
    chk({tag, "_hit_count"}, 32'(hit_count), 32'd0);
  endtask

  // Advance one clock and compare at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    chk_model();
    if (!quiet && req_ack != '0)
      $display("txn ack=%b src=%0d id=%04h hits=%0d", req_ack, evt_src, evt_id, hit_count);
  endtask

  // Called at a falling edge; reset stays low across one rising edge.
  task automatic reset_dut();
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_id    = '0;
    bp_enable = '0;
    evt_ready = 1'b0;
    resume    = 1'b0;
    @(negedge clk);
    reset_dut();

    // Single request end to end.
    bp_enable     = 4'hF;
    req_valid     = 4'b0001;
    req_id[15:0]  = 16'h00A5;
    evt_ready     = 1'b1;
    step();
    chk("single_evt_valid", 32'(evt_valid), 32'd1);
    chk("single_evt_src",   32'(evt_src),   32'd0);
    chk("single_evt_id",    32'(evt_id),    32'h00A5);
    chk("single_halt_iss",  32'(halt),      32'd1);
    step();
    chk("single_halt_hlt",  32'(halt),      32'd1);
    chk("single_valid_hlt", 32'(evt_valid), 32'd0);
    resume = 1'b1;
    step();
    resume    = 1'b0;
    req_valid = 4'b0000;
    chk("single_ack",       32'(req_ack),   32'b0001);
    chk("single_hits",      32'(hit_count), 32'd1);
    chk("single_halt_idle", 32'(halt),      32'd0);
    step();
    chk("single_ack_gone",  32'(req_ack),   32'd0);

    // Stray resume and evt_ready while idle.
    resume = 1'b1;
    step();
    resume = 1'b0;
    chk("stray_ack",  32'(req_ack),   32'd0);
    chk("stray_hits", 32'(hit_count), 32'd1);
    chk("stray_halt", 32'(halt),      32'd0);

    // Fairness with every requester held valid.
    reset_dut();
    req_valid = 4'hF;
    bp_enable = 4'hF;
    evt_ready = 1'b1;
    for (int s = 0; s < 5; s++) begin
      step();
      chk("fair_order", 32'(evt_src), 32'(s % 4));
      step();
      resume = 1'b1;
      step();
      resume = 1'b0;
    end
    chk("fair_hits", 32'(hit_count), 32'd5);

    // Masking: requester 1 valid but disabled is never granted.
    reset_dut();
    req_valid = 4'b0110;
    bp_enable = 4'b0100;
    evt_ready = 1'b1;
    step();
    chk("mask_src",   32'(evt_src),   32'd2);
    chk("mask_valid", 32'(evt_valid), 32'd1);
    step();
    resume = 1'b1;
    step();
    resume    = 1'b0;
    req_valid = 4'b0010;
    chk("mask_ack", 32'(req_ack), 32'b0100);
    repeat (4) begin
      step();
      chk("mask_no_grant", 32'(evt_valid), 32'd0);
    end

    // Backpressure: ID bus changes while the event waits.
    reset_dut();
    req_valid    = 4'b0001;
    bp_enable    = 4'hF;
    req_id[15:0] = 16'h1234;
    evt_ready    = 1'b0;
    step();
    chk("bp_valid0", 32'(evt_valid), 32'd1);
    repeat (5) begin
      req_id = {N*IW/32{$urandom}};
      step();
      chk("bp_valid", 32'(evt_valid), 32'd1);
      chk("bp_id",    32'(evt_id),    32'h1234);
      chk("bp_halt",  32'(halt),      32'd1);
    end
    evt_ready = 1'b1;
    step();
    chk("bp_to_halt_valid", 32'(evt_valid), 32'd0);
    chk("bp_to_halt_halt",  32'(halt),      32'd1);

    // Reset while halted, with resume pending: no ack, next grant to 0.
    resume = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("halt_rst");
    @(negedge clk);
    chk("halt_rst_no_ack", 32'(req_ack),   32'd0);
    chk("halt_rst_hits",   32'(hit_count), 32'd0);
    rst_n     = 1'b1;
    resume    = 1'b0;
    req_valid = 4'hF;
    step();
    chk("halt_rst_first", 32'(evt_src), 32'd0);

    // Saturation: 65535 services, then one more.
    reset_dut();
    quiet     = 1'b1;
    req_valid = 4'b0011;
    bp_enable = 4'hF;
    evt_ready = 1'b1;
    step();
    for (int s = 0; s < 65535; s++) begin
      step();
      resume = 1'b1;
      step();
      resume = 1'b0;
      step();
    end
    quiet = 1'b0;
    $display("txn bulk services done hits=%0d", hit_count);
    chk("sat_reach", 32'(hit_count), 32'hFFFF);
    step();
    resume = 1'b1;
    step();
    resume = 1'b0;
    chk("sat_hold_ack",  32'(req_ack != '0), 32'd1);
    chk("sat_hold_hits", 32'(hit_count),     32'hFFFF);

    // Randomized traffic with occasional resets.
    reset_dut();
    req_valid = '0;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) begin
        if (req_ack[i]) begin
          req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i]      = 1'b1;
          req_id[i*IW +: IW] = IW'($urandom);
        end
      end
      if ($urandom_range(0, 15) == 0) bp_enable = N'($urandom);
      evt_ready = 1'($urandom_range(0, 1));
      resume    = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 599) == 0) reset_dut();
      else step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hgdb_bp_arbiter.md
HGDB_BP_ARBITER -- requirements
Module: hgdb_bp_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of breakpoint requesters (legal range 2..16).
REQ-002 The block SHALL have parameter ID_WIDTH, default 16, giving the breakpoint ID width.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  NUM_REQ  per-requester breakpoint-hit request, held until acked.
REQ-006 req_id  input  NUM_REQ*ID_WIDTH  per-requester breakpoint ID; slice i = [i*ID_WIDTH +: ID_WIDTH].
REQ-007 bp_enable  input  NUM_REQ  per-requester enable mask from the debugger runtime.
REQ-008 evt_valid  output  1  event offered to the runtime channel.
REQ-009 evt_ready  input  1  runtime accepts the event.
REQ-010 evt_src  output  clog2(NUM_REQ)  index of the granted requester.
REQ-011 evt_id  output  ID_WIDTH  breakpoint ID of the granted requester.
REQ-012 resume  input  1  single-cycle pulse from the runtime releasing the halt.
REQ-013 halt  output  1  design-stall request while a breakpoint is being serviced.
REQ-014 req_ack  output  NUM_REQ  one-hot, single-cycle completion pulse to the granted requester.
REQ-015 hit_count  output  16  count of serviced breakpoints, saturating.

Function
REQ-016 The state machine SHALL have states IDLE, ISSUE and HALT.
REQ-017 eligible SHALL be defined as req_valid & bp_enable & ~req_ack.
REQ-018 In IDLE with eligible != 0, the block SHALL grant round-robin, searching from index ptr+1 upward with wrap-around, where ptr is the last granted index.
REQ-019 On a grant, the block SHALL latch evt_src and evt_id and enter ISSUE on the next edge, so that req_valid seen at cycle t gives evt_valid=1 at cycle t+1.
REQ-020 In IDLE with eligible == 0, the block SHALL remain in IDLE with evt_valid=0.
REQ-021 In ISSUE, evt_valid SHALL be 1 and evt_src/evt_id SHALL be held stable until evt_valid & evt_ready.
REQ-022 On evt_valid & evt_ready, the block SHALL enter HALT, with evt_valid=0 from the next cycle.
REQ-023 halt SHALL be 1 in ISSUE and HALT, and 0 in IDLE.
REQ-024 In HALT, on resume=1 the block SHALL enter IDLE with req_ack[evt_src]=1 for exactly that one cycle.
REQ-025 On the same transition (HALT to IDLE on resume), ptr SHALL be set to evt_src and hit_count SHALL increment, holding at 0xFFFF once reached.
REQ-026 resume asserted in IDLE or ISSUE SHALL be ignored.
REQ-027 evt_ready asserted outside ISSUE SHALL be ignored.
REQ-028 Deassertion of req_valid or bp_enable for the granted requester during ISSUE or HALT SHALL NOT abort the transaction; the ack is still issued.
REQ-029 Requesters SHALL deassert req_valid no later than the cycle after req_ack; the ack-cycle mask (REQ-017) prevents an immediate re-grant.
REQ-030 Minimum service time SHALL be 3 cycles from grant to ack (ISSUE with evt_ready=1, HALT with resume=1, then IDLE with ack).

Reset
REQ-031 While rst_n=0, asynchronously: state=IDLE; evt_valid=0; halt=0; req_ack=0; evt_src=0; evt_id=0; hit_count=0; ptr=NUM_REQ-1, so requester 0 has first priority.
REQ-032 Reset asserted in ISSUE or HALT SHALL discard the pending event without issuing req_ack, and SHALL leave hit_count at 0.

Verification
REQ-033 Single request: req_valid=0001, bp_enable=1111, req_id[0]=0x00A5, evt_ready=1, resume pulsed 2 cycles later -> evt_valid at t+1 with evt_src=0, evt_id=0x00A5; halt high through HALT; req_ack=0001 for one cycle; hit_count=1.
REQ-034 Fairness: all four requesters held valid and each acked in turn -> grant order 0,1,2,3,0 and hit_count=5.
REQ-035 Masking: req_valid=0110, bp_enable=0100 -> only requester 2 is granted; requester 1 is never evt_src while its enable is 0.
REQ-036 Backpressure: evt_ready=0 for 5 cycles, req_id changing meanwhile -> evt_valid stays 1, evt_id stays at the latched value, halt=1, no state change; evt_ready=1 -> HALT.
REQ-037 Stray and edge events: resume pulsed in IDLE -> no ack and no count change; hit_count preloaded to 0xFFFF via 65535 services -> remains 0xFFFF after the next service.
REQ-038 Reset in HALT: rst_n pulled low mid-HALT -> outputs immediately return to the reset values, no req_ack pulse, and the next grant goes to requester 0.
